tluh_sram_arbiter: RTL and testbench
====================================

Name: tluh_sram_arbiter

Overview:
- Shares one single-port SRAM macro between NumReq SRAM-side requesters. Each requester is a tluh_sram_adapter instance, e.g. the core I-port adapter and the D-port adapter.
- Arbitration is round-robin, with a lock so an atomic read-modify-write from tluh_sram_adapter stays indivisible.
- Tracks outstanding reads in an ID FIFO and routes each SRAM read response back to the requester that issued the read.

Parameters:
- NumReq, 2, number of requesters (2..4).
- SramAw, 12, SRAM word-address width.
- SramDw, 32, SRAM data width.
- RdDepth, 2, maximum outstanding reads (ID FIFO depth, at least 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- req_i  in  NumReq  per-requester access request.
- lock_i  in  NumReq  hold ownership after this grant (atomic read phase).
- we_i  in  NumReq  write enable.
- addr_i  in  NumReq*SramAw  word addresses, requester k at [k*SramAw+:SramAw].
- wdata_i  in  NumReq*SramDw  write data.
- wmask_i  in  NumReq*SramDw  bit write mask.
- gnt_o  out  NumReq  one-hot grant, combinational.
- rvalid_o  out  NumReq  read response valid, one-hot.
- rdata_o  out  SramDw  read data, broadcast to all requesters.
- rerror_o  out  2  read error, broadcast to all requesters.
- sram_req_o  out  1  SRAM request.
- sram_gnt_i  in  1  SRAM grant.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  SramAw  SRAM address.
- sram_wdata_o  out  SramDw  SRAM write data.
- sram_wmask_o  out  SramDw  SRAM write mask.
- sram_rdata_i  in  SramDw  SRAM read data.
- sram_rvalid_i  in  1  SRAM read valid (writes never return rvalid).
- sram_rerror_i  in  2  SRAM read error.
- spurious_o  out  1  one-cycle pulse: sram_rvalid_i arrived with no read outstanding.

Interface: one clock; reset is asynchronous and active-high. Clock port is clk_i, reset port is rst_i.

Behaviour:
- State:
  - rr_ptr: requester with highest priority.
  - owner and owned: current lock holder.
  - ID FIFO: RdDepth entries, each $clog2(NumReq) bits wide, with wrap-around read and write pointers and a count.
- Reset, asynchronous, while rst_i is high:
  - rr_ptr=0, owned=0, FIFO empty (pointers and count 0).
  - gnt_o=0, sram_req_o=0, rvalid_o=0, spurious_o=0.
  - rdata_o=0, rerror_o=0, sram_we_o=0, addr/wdata/wmask outputs=0.
- Eligibility: requester k is eligible when req_i[k]=1, (owned=0 or owner=k), and (we_i[k]=1 or rd_ok).
  - rd_ok = (count<RdDepth) or (sram_rvalid_i=1 and count>0), i.e. a same-cycle pop frees a slot.
- Winner: first eligible k scanning from rr_ptr upward, wrapping modulo NumReq.
- Forwarding, combinational, same cycle:
  - sram_req_o=1 iff a winner exists.
  - sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o are the winner's signals, else 0.
  - gnt_o[winner] = sram_req_o & sram_gnt_i.
- Accepted transfer: a cycle where gnt_o is nonzero.
  - Read accepted: push winner ID into the FIFO at the next edge.
  - Lock: if lock_i[winner]=1, set owned=1, owner=winner.
  - Unlock: if owned and lock_i[owner]=0, clear owned. rr_ptr is then updated as normal.
  - Round-robin: rr_ptr <= (winner+1) mod NumReq, only when the lock is not held after this edge. While owned, rr_ptr is frozen.
- Denied cycle: if sram_gnt_i=0 there is no push, no pointer change, no lock change. Requesters keep their request held.
- Responses:
  - When sram_rvalid_i=1 and count>0: rvalid_o[FIFO head]=1, rdata_o=sram_rdata_i, rerror_o=sram_rerror_i, pop at the edge. Response latency is 0 cycles from SRAM to requester.
  - When sram_rvalid_i=1 and count=0: rvalid_o=0 and spurious_o=1 for that cycle, FIFO unchanged.
  - Otherwise rvalid_o=0 and rdata_o=0.
- Push and pop in the same cycle: count unchanged, both pointers advance. Both pointers wrap at RdDepth.
- Reads against a full FIFO:
  - Reads are blocked when full with no pop that cycle.
  - Writes still proceed, including from the lock owner.
- Lock holder deasserts req_i without unlocking: the lock persists, and other requesters starve. This is the requester's responsibility; tluh_sram_adapter always completes the RMW.
- Reset asserted mid-operation: FIFO contents dropped and lock cleared. In-flight SRAM rvalid after reset release is reported as spurious.

Test Plan:
- Reset, then req_i=2'b11 as reads to addr 0x1 and 0x2, sram_gnt_i=1, SRAM latency 1:
  - gnt_o=01 then 10.
  - rvalid_o=01 with data[1], then 10 with data[2].
- Continuous requests from both, 6 cycles, all writes: grants alternate 01,10,01,10,01,10.
- Requester 1 read with lock_i=1 to 0xC, while requester 0 requests continuously:
  - Requester 0 is not granted until requester 1's write to 0xC with lock_i=0 is granted.
  - The next grant goes to requester 0.
- RdDepth=2, SRAM withholds rvalid:
  - Two reads granted, a third read gets gnt_o=0.
  - A write from the other requester is still granted.
  - First rvalid releases the third read in the same cycle.
- sram_gnt_i=0 for 3 cycles while req_i=01: gnt_o=0 with sram_req_o held, and the grant follows on the cycle sram_gnt_i=1.
- Spurious rvalid and mid-operation reset:
  - sram_rvalid_i=1 with the FIFO empty gives spurious_o=1 for one cycle and rvalid_o=0.
  - rst_i pulse with 1 read outstanding, followed by rvalid, gives spurious_o=1.

Source files
------------

// File: rtl/tluh_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters,
// with an atomic lock and an ID FIFO that steers read responses back to their issuer.
module tluh_sram_arbiter #(
  parameter int NumReq  = 2,
  parameter int SramAw  = 12,
  parameter int SramDw  = 32,
  parameter int RdDepth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        lock_i,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq*SramAw-1:0] addr_i,
  input  logic [NumReq*SramDw-1:0] wdata_i,
  input  logic [NumReq*SramDw-1:0] wmask_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [SramDw-1:0]        rdata_o,
  output logic [1:0]               rerror_o,
  output logic                     sram_req_o,
  input  logic                     sram_gnt_i,
  output logic                     sram_we_o,
  output logic [SramAw-1:0]        sram_addr_o,
  output logic [SramDw-1:0]        sram_wdata_o,
  output logic [SramDw-1:0]        sram_wmask_o,
  input  logic [SramDw-1:0]        sram_rdata_i,
  input  logic                     sram_rvalid_i,
  input  logic [1:0]               sram_rerror_i,
  output logic                     spurious_o
);
  localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int PtrW = (RdDepth > 1) ? $clog2(RdDepth) : 1;
  localparam int CntW = $clog2(RdDepth + 1);

  logic [IdW-1:0]  r_rr_ptr;
  logic [IdW-1:0]  r_owner;
  logic            r_owned;
  logic [IdW-1:0]  r_fifo [RdDepth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic              w_pop;
  logic              w_rd_ok;
  logic              w_found;
  logic              w_hi;
  logic              w_accept;
  logic              w_push;
  logic [NumReq-1:0] w_elig;
  logic [IdW-1:0]    w_win;
  logic [IdW-1:0]    w_win_hi;
  logic [IdW-1:0]    w_win_inc;
  logic [IdW-1:0]    w_head;
  logic [SramAw-1:0] w_addr  [NumReq];
  logic [SramDw-1:0] w_wdata [NumReq];
  logic [SramDw-1:0] w_wmask [NumReq];

  // A response popping this cycle frees a FIFO slot for a read granted in the same cycle.
  assign w_pop   = sram_rvalid_i && (r_count != '0);
  assign w_rd_ok = (r_count < CntW'(RdDepth)) || w_pop;
  assign w_head  = r_fifo[r_rptr];

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_req
      assign w_addr[gi]   = addr_i[gi*SramAw +: SramAw];
      assign w_wdata[gi]  = wdata_i[gi*SramDw +: SramDw];
      assign w_wmask[gi]  = wmask_i[gi*SramDw +: SramDw];
      assign w_elig[gi]   = req_i[gi] && (!r_owned || (r_owner == IdW'(gi))) &&
                            (we_i[gi] || w_rd_ok);
      assign gnt_o[gi]    = w_accept && (w_win == IdW'(gi));
      assign rvalid_o[gi] = w_pop && !rst_i && (w_head == IdW'(gi));
    end
  endgenerate

  // Two-pass scan: first eligible at or above rr_ptr, else the lowest eligible overall.
  always_comb begin
    w_found  = 1'b0;
    w_hi     = 1'b0;
    w_win    = '0;
    w_win_hi = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (!w_hi && w_elig[k] && (IdW'(k) >= r_rr_ptr)) begin
        w_hi     = 1'b1;
        w_win_hi = IdW'(k);
      end
      if (!w_found && w_elig[k]) begin
        w_found = 1'b1;
        w_win   = IdW'(k);
      end
    end
    if (w_hi) w_win = w_win_hi;
  end

  assign w_win_inc    = (w_win == IdW'(NumReq - 1)) ? '0 : w_win + 1'b1;
  assign sram_req_o   = w_found && !rst_i;
  assign w_accept     = sram_req_o && sram_gnt_i;
  assign w_push       = w_accept && !we_i[w_win];
  assign sram_we_o    = sram_req_o ? we_i[w_win]    : 1'b0;
  assign sram_addr_o  = sram_req_o ? w_addr[w_win]  : '0;
  assign sram_wdata_o = sram_req_o ? w_wdata[w_win] : '0;
  assign sram_wmask_o = sram_req_o ? w_wmask[w_win] : '0;

  assign rdata_o    = (w_pop && !rst_i) ? sram_rdata_i  : '0;
  assign rerror_o   = (w_pop && !rst_i) ? sram_rerror_i : 2'b00;
  assign spurious_o = sram_rvalid_i && (r_count == '0) && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_owned  <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      // Only the owner can win while locked, so the winner's lock bit decides both lock and unlock.
      if (w_accept) begin
        r_owned <= lock_i[w_win];
        r_owner <= w_win;
        if (!lock_i[w_win]) r_rr_ptr <= w_win_inc;
      end
      if (w_push) r_wptr <= (r_wptr == PtrW'(RdDepth - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PtrW'(RdDepth - 1)) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_win;
  end

endmodule

// File: tb/tb_tluh_sram_arbiter.sv
// Directed bench for tluh_sram_arbiter: a queue-based reference model checks every
// cycle, and literal expectations at key steps pin that model to the intended behaviour.
module tb_tluh_sram_arbiter;
  logic        clk;
  logic        rst;
  logic [1:0]  req, lock, we;
  logic [23:0] addr;
  logic [63:0] wdata, wmask;
  logic        sram_gnt, sram_rvalid;
  logic [31:0] sram_rdata;
  logic [1:0]  sram_rerror;
  logic [1:0]  gnt, rvalid, rerror;
  logic [31:0] rdata;
  logic        sram_req, sram_we, spurious;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata, sram_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  tluh_sram_arbiter #(.NumReq(2), .SramAw(12), .SramDw(32), .RdDepth(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .gnt_o(gnt),
    .rvalid_o(rvalid), .rdata_o(rdata), .rerror_o(rerror),
    .sram_req_o(sram_req), .sram_gnt_i(sram_gnt), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask),
    .sram_rdata_i(sram_rdata), .sram_rvalid_i(sram_rvalid), .sram_rerror_i(sram_rerror),
    .spurious_o(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dat(input logic [11:0] a);
    return 32'hDA7A_0000 | {20'h0, a};
  endfunction

  task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                       input logic [11:0] a0, input logic [11:0] a1,
                       input logic g, input logic rv, input logic [31:0] rd);
    req         = r;
    lock        = l;
    we          = w;
    addr        = {a1, a0};
    wdata       = {32'hB000_0000 | {20'h0, a1}, 32'hA000_0000 | {20'h0, a0}};
    wmask       = {32'hFFFF_0000, 32'h0000_FFFF};
    sram_gnt    = g;
    sram_rvalid = rv;
    sram_rdata  = rd;
    sram_rerror = rv ? rd[1:0] : 2'b00;
  endtask

  // Advance one cycle, apply new inputs, then stop at the negedge for literal checks.
  task automatic cyc(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                     input logic [11:0] a0, input logic [11:0] a1,
                     input logic g, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    drive(r, l, w, a0, a1, g, rv, rd);
    @(negedge clk);
  endtask

  // Reference model: round-robin pointer, lock holder and a queue of outstanding read IDs.
  int       m_rr;
  bit       m_owned;
  int       m_owner;
  int       m_q[$];
  int       win, k;
  bit       pop, rd_ok;
  logic [1:0]  e_gnt, e_rvalid, e_rerror;
  logic [31:0] e_rdata;
  logic [76:0] e_fwd;

  initial begin
    m_rr = 0; m_owned = 0; m_owner = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_q.delete();
        m_rr = 0; m_owned = 0; m_owner = 0;
        chk("rst_zero", {gnt, rvalid, sram_req, spurious, rerror, sram_we, rdata,
                         sram_addr, sram_wdata, sram_wmask}, '0);
      end else begin
        pop   = sram_rvalid && (m_q.size() > 0);
        rd_ok = (m_q.size() < 2) || pop;
        win   = -1;
        for (int i = 0; i < 2; i++) begin
          k = (m_rr + i) % 2;
          if (win < 0 && req[k[0]] && (!m_owned || m_owner == k) && (we[k[0]] || rd_ok))
            win = k;
        end
        e_gnt = (win >= 0 && sram_gnt) ? (2'b01 << win) : 2'b00;
        if (win == 0)      e_fwd = {we[0], addr[11:0],  wdata[31:0],  wmask[31:0]};
        else if (win == 1) e_fwd = {we[1], addr[23:12], wdata[63:32], wmask[63:32]};
        else               e_fwd = '0;
        e_rvalid = pop ? (2'b01 << m_q[0]) : 2'b00;
        e_rdata  = pop ? sram_rdata  : 32'h0;
        e_rerror = pop ? sram_rerror : 2'b00;
        chk("gnt", gnt, e_gnt);
        chk("sram_req", sram_req, win >= 0);
        chk("fwd", {sram_we, sram_addr, sram_wdata, sram_wmask}, e_fwd);
        chk("rvalid", rvalid, e_rvalid);
        chk("rdata", rdata, e_rdata);
        chk("rerror", rerror, e_rerror);
        chk("spurious", spurious, sram_rvalid && (m_q.size() == 0));
        if (pop) begin
          $display("txn t=%0t resp   id=%0d rdata=%h", $time, m_q[0], sram_rdata);
          void'(m_q.pop_front());
        end
        if (e_gnt != 2'b00) begin
          $display("txn t=%0t grant  req=%0d we=%b addr=%h lock=%b", $time, win,
                   e_fwd[76], e_fwd[75:64], lock[win[0]]);
          if (!we[win[0]]) m_q.push_back(win);
          if (lock[win[0]]) begin
            m_owned = 1; m_owner = win;
          end else begin
            m_owned = 0; m_rr = (win + 1) % 2;
          end
        end
      end
    end
  end

  logic [1:0] alt_exp [6];

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 1'b0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("lit_rst_gnt", gnt, 2'b00);
      chk("lit_rst_req", sram_req, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two reads, SRAM latency 1.
    cyc(2'b11, 2'b00, 2'b00, 12'h1, 12'h2, 1'b1, 1'b0, 32'h0);
    chk("lit_rd_gnt0", gnt, 2'b01);
    chk("lit_rd_addr0", sram_addr, 12'h1);
    cyc(2'b10, 2'b00, 2'b00, 12'h1, 12'h2, 1'b1, 1'b1, dat(12'h1));
    chk("lit_rd_gnt1", gnt, 2'b10);
    chk("lit_rd_rvalid0", rvalid, 2'b01);
    chk("lit_rd_rdata0", rdata, 32'hDA7A_0001);
    cyc(2'b00, 2'b00, 2'b00, 12'h1, 12'h2, 1'b1, 1'b1, dat(12'h2));
    chk("lit_rd_rvalid1", rvalid, 2'b10);
    chk("lit_rd_rdata1", rdata, 32'hDA7A_0002);

    // Continuous writes from both requesters alternate.
    alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 6; i++) begin
      cyc(2'b11, 2'b00, 2'b11, 12'h10 + 12'(i), 12'h20 + 12'(i), 1'b1, 1'b0, 32'h0);
      chk("lit_alt_gnt", gnt, alt_exp[i]);
    end

    // Lock: requester 1 does a locked read then unlocking write; requester 0 starves meanwhile.
    cyc(2'b01, 2'b00, 2'b01, 12'h5, 12'h5, 1'b1, 1'b0, 32'h0);
    chk("lit_pre_lock", gnt, 2'b01);
    cyc(2'b11, 2'b10, 2'b01, 12'h6, 12'hC, 1'b1, 1'b0, 32'h0);
    chk("lit_lock_rd", gnt, 2'b10);
    cyc(2'b01, 2'b10, 2'b01, 12'h6, 12'hC, 1'b1, 1'b1, dat(12'hC));
    chk("lit_lock_hold", gnt, 2'b00);
    chk("lit_lock_rvalid", rvalid, 2'b10);
    cyc(2'b01, 2'b10, 2'b01, 12'h6, 12'hC, 1'b1, 1'b0, 32'h0);
    chk("lit_lock_hold2", gnt, 2'b00);
    cyc(2'b11, 2'b00, 2'b11, 12'h6, 12'hC, 1'b1, 1'b0, 32'h0);
    chk("lit_lock_wr", gnt, 2'b10);
    cyc(2'b01, 2'b00, 2'b01, 12'h6, 12'hC, 1'b1, 1'b0, 32'h0);
    chk("lit_unlock_next", gnt, 2'b01);

    // Outstanding-read limit.
    cyc(2'b01, 2'b00, 2'b00, 12'h3, 12'h7, 1'b1, 1'b0, 32'h0);
    chk("lit_full_rd1", gnt, 2'b01);
    cyc(2'b10, 2'b00, 2'b00, 12'h3, 12'h7, 1'b1, 1'b0, 32'h0);
    chk("lit_full_rd2", gnt, 2'b10);
    cyc(2'b01, 2'b00, 2'b00, 12'h3, 12'h7, 1'b1, 1'b0, 32'h0);
    chk("lit_full_block", gnt, 2'b00);
    cyc(2'b11, 2'b00, 2'b10, 12'h3, 12'h7, 1'b1, 1'b0, 32'h0);
    chk("lit_full_wr", gnt, 2'b10);
    cyc(2'b01, 2'b00, 2'b00, 12'h3, 12'h7, 1'b1, 1'b1, dat(12'h3));
    chk("lit_full_release", gnt, 2'b01);
    chk("lit_full_rvalid", rvalid, 2'b01);
    cyc(2'b00, 2'b00, 2'b00, 12'h3, 12'h7, 1'b1, 1'b1, dat(12'h7));
    chk("lit_drain1", rvalid, 2'b10);
    cyc(2'b00, 2'b00, 2'b00, 12'h3, 12'h7, 1'b1, 1'b1, dat(12'h3));
    chk("lit_drain2", rvalid, 2'b01);

    // SRAM back-pressure.
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 2'b00, 2'b01, 12'h9, 12'h9, 1'b0, 1'b0, 32'h0);
      chk("lit_stall_gnt", gnt, 2'b00);
      chk("lit_stall_req", sram_req, 1'b1);
    end
    cyc(2'b01, 2'b00, 2'b01, 12'h9, 12'h9, 1'b1, 1'b0, 32'h0);
    chk("lit_stall_release", gnt, 2'b01);

    // Spurious response, then reset with a read outstanding.
    cyc(2'b00, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 1'b1, dat(12'h5));
    chk("lit_spur", spurious, 1'b1);
    chk("lit_spur_rvalid", rvalid, 2'b00);
    cyc(2'b00, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 1'b0, 32'h0);
    chk("lit_spur_clear", spurious, 1'b0);
    cyc(2'b01, 2'b00, 2'b00, 12'h8, 12'h8, 1'b1, 1'b0, 32'h0);
    chk("lit_pre_rst_rd", gnt, 2'b01);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("lit_midrst_gnt", gnt, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(2'b00, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 1'b1, dat(12'h8));
    chk("lit_post_rst_spur", spurious, 1'b1);
    chk("lit_post_rst_rvalid", rvalid, 2'b00);
    cyc(2'b00, 2'b00, 2'b00, 12'h0, 12'h0, 1'b1, 1'b0, 32'h0);
    chk("lit_post_rst_idle", spurious, 1'b0);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
